// File: rtl/raw2rgb_bayer_p.sv
// Streaming Bayer-to-RGB converter: one previous-line buffer, 2x2 window demosaic, output x/y coordinates.
// Optional macro RAW2RGB_GAIN_EN adds a saturating 4.4 per-channel gain stage (latency 3 instead of 2).
module raw2rgb_bayer_p #(
    parameter int DW        = 12,
    parameter int MAX_W     = 640,
    parameter int XW        = 11,
    parameter int BAYER_PAT = 0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          i_fval,
    input  logic          i_lval,
    input  logic [DW-1:0] i_data,
    input  logic [7:0]    i_gain_r,
    input  logic [7:0]    i_gain_g,
    input  logic [7:0]    i_gain_b,
    output logic [DW-1:0] o_r,
    output logic [DW-1:0] o_g,
    output logic [DW-1:0] o_b,
    output logic          o_dval,
    output logic [XW-1:0] o_x,
    output logic [XW-1:0] o_y,
    output logic          o_ovf
);

    localparam int         AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [1:0] PAT   = 2'(BAYER_PAT);
    localparam logic [XW:0] MAX_X = (XW+1)'(MAX_W);

    // x carries one extra bit so a line of exactly 2^XW pixels cannot wrap back into range
    logic [XW:0]   r_x;
    logic [XW-1:0] r_y;
    logic          r_lval_d;
    logic          r_fval_d;
    logic          r_ovf;

    logic          w_line;
    logic          w_in_range;
    logic          w_acc;
    logic [AW-1:0] w_addr;

    assign w_line     = i_fval & i_lval;
    assign w_in_range = (r_x < MAX_X);
    assign w_acc      = w_line & w_in_range;
    assign w_addr     = r_x[AW-1:0];
    assign o_ovf      = r_ovf;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_x      <= '0;
            r_y      <= '0;
            r_lval_d <= 1'b0;
            r_fval_d <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_lval_d <= w_line;
            r_fval_d <= i_fval;
            if (!w_line)
                r_x <= '0;
            else if (w_in_range)
                r_x <= r_x + 1'b1;
            if (!i_fval)
                r_y <= '0;
            else if (r_lval_d && !i_lval)
                r_y <= r_y + 1'b1;
            if (i_fval && !r_fval_d)
                r_ovf <= 1'b0;
            else if (w_line && !w_in_range)
                r_ovf <= 1'b1;
        end
    end

    // Line buffer, read-before-write: r_tr is the previous line's pixel at this column
    logic [DW-1:0] r_mem [MAX_W];
    logic [DW-1:0] r_tr;

    always_ff @(posedge CLK) begin
        if (w_acc) begin
            r_tr          <= r_mem[w_addr];
            r_mem[w_addr] <= i_data;
        end
    end

    logic [DW-1:0] r_tl;
    logic [DW-1:0] r_bl;
    logic [DW-1:0] r_br;
    logic [XW-1:0] r_x1;
    logic [XW-1:0] r_y1;
    logic [1:0]    r_ph;
    logic          r_v1;

    // r_ph is the phase of TL, i.e. of (x-1, y-1): both parities flip relative to BR
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tl <= '0;
            r_bl <= '0;
            r_br <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
            r_ph <= '0;
            r_v1 <= 1'b0;
        end else begin
            if (w_acc) begin
                r_tl <= r_tr;
                r_bl <= r_br;
                r_br <= i_data;
                r_x1 <= r_x[XW-1:0];
                r_y1 <= r_y;
                r_ph <= {~r_y[0] ^ PAT[1], ~r_x[0] ^ PAT[0]};
            end
            r_v1 <= w_acc && (r_x != '0) && (r_y != '0);
        end
    end

    logic [DW-1:0] w_r;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_g1;
    logic [DW-1:0] w_g2;
    logic [DW:0]   w_gsum;
    logic [DW-1:0] w_g;

    always_comb begin
        w_r  = r_tl;
        w_b  = r_br;
        w_g1 = r_tr;
        w_g2 = r_bl;
        case (r_ph)
            2'b01: begin
                w_r  = r_tr;
                w_b  = r_bl;
                w_g1 = r_tl;
                w_g2 = r_br;
            end
            2'b10: begin
                w_r  = r_bl;
                w_b  = r_tr;
                w_g1 = r_tl;
                w_g2 = r_br;
            end
            2'b11: begin
                w_r  = r_br;
                w_b  = r_tl;
                w_g1 = r_tr;
                w_g2 = r_bl;
            end
            default: ;
        endcase
        w_gsum = {1'b0, w_g1} + {1'b0, w_g2};
        w_g    = w_gsum[DW:1];
    end

`ifdef RAW2RGB_GAIN_EN
    function automatic logic [DW-1:0] f_gain(input logic [DW-1:0] ch, input logic [7:0] gain);
        logic [DW+7:0] prod;
        prod = ch * gain;
        if (|prod[DW+7:DW+4])
            return '1;
        return prod[DW+3:4];
    endfunction

    logic [DW-1:0] r_r2;
    logic [DW-1:0] r_g2;
    logic [DW-1:0] r_b2;
    logic [7:0]    r_gain_r;
    logic [7:0]    r_gain_g;
    logic [7:0]    r_gain_b;
    logic [XW-1:0] r_x2;
    logic [XW-1:0] r_y2;
    logic          r_v2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_r2     <= '0;
            r_g2     <= '0;
            r_b2     <= '0;
            r_gain_r <= '0;
            r_gain_g <= '0;
            r_gain_b <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
            r_v2     <= 1'b0;
            o_r      <= '0;
            o_g      <= '0;
            o_b      <= '0;
            o_x      <= '0;
            o_y      <= '0;
            o_dval   <= 1'b0;
        end else begin
            if (r_v1 && i_fval) begin
                r_r2     <= w_r;
                r_g2     <= w_g;
                r_b2     <= w_b;
                r_gain_r <= i_gain_r;
                r_gain_g <= i_gain_g;
                r_gain_b <= i_gain_b;
                r_x2     <= r_x1;
                r_y2     <= r_y1;
            end
            r_v2 <= r_v1 && i_fval;
            if (r_v2 && i_fval) begin
                o_r <= f_gain(r_r2, r_gain_r);
                o_g <= f_gain(r_g2, r_gain_g);
                o_b <= f_gain(r_b2, r_gain_b);
                o_x <= r_x2;
                o_y <= r_y2;
            end
            o_dval <= r_v2 && i_fval;
        end
    end
`else
    logic w_unused_gain;
    assign w_unused_gain = ^{i_gain_r, i_gain_g, i_gain_b};

    // Gating with i_fval drops whatever is in flight the cycle a frame is cut short
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_r    <= '0;
            o_g    <= '0;
            o_b    <= '0;
            o_x    <= '0;
            o_y    <= '0;
            o_dval <= 1'b0;
        end else begin
            if (r_v1 && i_fval) begin
                o_r <= w_r;
                o_g <= w_g;
                o_b <= w_b;
                o_x <= r_x1;
                o_y <= r_y1;
            end
            o_dval <= r_v1 && i_fval;
        end
    end
`endif

endmodule
